bram_port_arbiter: RTL and testbench

- Sits directly upstream of the dual-port block RAM's port A.
- Lets two clients share that single port: client 0 is the CPU load/store unit, client 1 is the video/pong object fetcher.
- Each cycle it accepts at most one request (read or write) using round-robin arbitration, registers it onto the BRAM port, and returns read data to the issuing client with a fixed latency.

---
 rtl/bram_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/bram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM port A arbiter: size defaults, client ids
// and the read-return tag carried down the latency pipeline.
package bram_pkg;

  localparam int BRAM_DATA_WIDTH = 16;
  localparam int BRAM_ADDR_WIDTH = 10;
  localparam int BRAM_READ_LAT   = 1;

  localparam logic CLIENT_CPU = 1'b0;
  localparam logic CLIENT_VID = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, and on a tie
// the client that did not win last time gets the port.
module rr_arbiter2
  import bram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // Pick the single winner from the request pair and the last grant
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == CLIENT_CPU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port A between the CPU load/store unit (client 0) and the
// video object fetcher (client 1). One request is accepted per cycle,
// registered onto the port, and read data is steered back to the issuing
// client after a fixed latency using a small tag shift register.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = bram_pkg::BRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = bram_pkg::BRAM_ADDR_WIDTH,
  parameter int READ_LAT   = bram_pkg::BRAM_READ_LAT
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_gnt,
  output logic                  c0_rvalid,
  output logic [DATA_WIDTH-1:0] c0_rdata,

  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_gnt,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] c1_rdata,

  output logic [DATA_WIDTH-1:0] data_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  we_a,
  input  logic [DATA_WIDTH-1:0] q_a
);

  import bram_pkg::*;

  logic [1:0]            req_v;
  logic [1:0]            gnt_v;
  logic                  last_gnt;
  logic                  any_gnt;
  logic                  gnt_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  tag_t [READ_LAT:0]     tag_pipe;
  tag_t                  tag_out;
  logic [DATA_WIDTH-1:0] c0_rdata_q;
  logic [DATA_WIDTH-1:0] c1_rdata_q;

  // Requests are masked while reset is held so nothing is granted then
  assign req_v = {c1_req, c0_req} & {2{reset}};

  rr_arbiter2 u_arb (
    .req      (req_v),
    .last_gnt (last_gnt),
    .gnt      (gnt_v)
  );

  assign c0_gnt  = gnt_v[0];
  assign c1_gnt  = gnt_v[1];
  assign any_gnt = |gnt_v;
  assign gnt_id  = gnt_v[1];

  // Route the winning client's fields towards the port registers
  always_comb begin
    sel_we    = c0_we;
    sel_addr  = c0_addr;
    sel_wdata = c0_wdata;
    if (gnt_id == CLIENT_VID) begin
      sel_we    = c1_we;
      sel_addr  = c1_addr;
      sel_wdata = c1_wdata;
    end
  end

  // Port A registers and round-robin history; idle cycles only drop we_a
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_a   <= '0;
      addr_a   <= '0;
      we_a     <= 1'b0;
      last_gnt <= CLIENT_VID;
    end else if (any_gnt) begin
      data_a   <= sel_wdata;
      addr_a   <= sel_addr;
      we_a     <= sel_we;
      last_gnt <= gnt_id;
    end else begin
      we_a     <= 1'b0;
    end
  end

  // Tag shift register: one stage per cycle between accept and q_a valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0].valid <= any_gnt & ~sel_we;
      tag_pipe[0].id    <= gnt_id;
      for (int i = 1; i <= READ_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out = tag_pipe[READ_LAT];

  assign c0_rvalid = reset & tag_out.valid & (tag_out.id == CLIENT_CPU);
  assign c1_rvalid = reset & tag_out.valid & (tag_out.id == CLIENT_VID);

  // Remember the last delivered word so rdata holds between pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
    end else begin
      if (c0_rvalid) c0_rdata_q <= q_a;
      if (c1_rvalid) c1_rdata_q <= q_a;
    end
  end

  assign c0_rdata = c0_rvalid ? q_a : c0_rdata_q;
  assign c1_rdata = c1_rvalid ? q_a : c1_rdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a write-first BRAM model on
// port A and a scoreboard of expected read returns.
module tb_bram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [DW-1:0] data_a, q_a;
  logic [AW-1:0] addr_a;
  logic          we_a;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } sb_entry_t;

  sb_entry_t     sb[$];
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic          started = 1'b0;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] exp_rd0, exp_rd1;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .c0_req    (c0_req),
    .c0_we     (c0_we),
    .c0_addr   (c0_addr),
    .c0_wdata  (c0_wdata),
    .c0_gnt    (c0_gnt),
    .c0_rvalid (c0_rvalid),
    .c0_rdata  (c0_rdata),
    .c1_req    (c1_req),
    .c1_we     (c1_we),
    .c1_addr   (c1_addr),
    .c1_wdata  (c1_wdata),
    .c1_gnt    (c1_gnt),
    .c1_rvalid (c1_rvalid),
    .c1_rdata  (c1_rdata),
    .data_a    (data_a),
    .addr_a    (addr_a),
    .we_a      (we_a),
    .q_a       (q_a)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time read returns
  always @(posedge clk) cyc <= cyc + 1;

  // Write-first single-cycle BRAM on port A
  always @(posedge clk) begin
    q_a <= we_a ? data_a : mem[addr_a];
    if (we_a) mem[addr_a] = data_a;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic r1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
    c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
  endtask

  task automatic stepCycle(input string tag, input logic exp_g0, input logic exp_g1);
    @(negedge clk);
    checkOutput({tag, "_g0"}, {31'd0, c0_gnt}, {31'd0, exp_g0});
    checkOutput({tag, "_g1"}, {31'd0, c1_gnt}, {31'd0, exp_g1});
    @(posedge clk);
    #1;
  endtask

  // Monitor: port registers, scoreboard pushes on grants, read-return checks
  always @(negedge clk) begin
    sb_entry_t e;
    if (started) begin
      checkOutput("we_a",   {31'd0, we_a},   {31'd0, exp_we});
      checkOutput("addr_a", {22'd0, addr_a}, {22'd0, exp_addr});
      checkOutput("data_a", {16'd0, data_a}, {16'd0, exp_data});
    end
    if (!reset) begin
      checkOutput("rst_gnt",    {30'd0, c1_gnt, c0_gnt},       32'd0);
      checkOutput("rst_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
      sb.delete();
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      exp_rd0 = '0; exp_rd1 = '0;
      started = 1'b1;
    end else if (started) begin
      checkOutput("one_gnt", {31'd0, c0_gnt & c1_gnt}, 32'd0);
      if (c0_gnt) begin
        exp_we = c0_we; exp_addr = c0_addr; exp_data = c0_wdata;
        if (c0_we) ref_mem[c0_addr] = c0_wdata;
        else sb.push_back('{id: 1'b0, data: ref_mem[c0_addr], due: cyc + RL + 1});
      end else if (c1_gnt) begin
        exp_we = c1_we; exp_addr = c1_addr; exp_data = c1_wdata;
        if (c1_we) ref_mem[c1_addr] = c1_wdata;
        else sb.push_back('{id: 1'b1, data: ref_mem[c1_addr], due: cyc + RL + 1});
      end else begin
        exp_we = 1'b0;
      end

      if (c0_rvalid || c1_rvalid) begin
        checkOutput("one_rvalid", {31'd0, c0_rvalid & c1_rvalid}, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("extra_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rv_id",    {31'd0, c1_rvalid}, {31'd0, e.id});
          checkOutput("rv_cycle", cyc, e.due);
          checkOutput("rdata",    {16'd0, (c1_rvalid ? c1_rdata : c0_rdata)}, {16'd0, e.data});
          if (e.id) exp_rd1 = e.data;
          else      exp_rd0 = e.data;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checkOutput("rv_missing", {30'd0, c1_rvalid, c0_rvalid}, e.id ? 32'd2 : 32'd1);
      end
      if (!c0_rvalid) checkOutput("c0_rdata_hold", {16'd0, c0_rdata}, {16'd0, exp_rd0});
      if (!c1_rvalid) checkOutput("c1_rdata_hold", {16'd0, c1_rdata}, {16'd0, exp_rd1});
    end
  end

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 16'hA000 | 16'(i);
      ref_mem[i] = 16'hA000 | 16'(i);
    end
    q_a   = '0;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 10'd3, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    stepCycle("rst_req", 1'b0, 1'b0);
    stepCycle("rst_req", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    stepCycle("rst_idle", 1'b0, 1'b0);
    reset = 1'b1;

    // First request after reset is a tie: client 0 wins, client 1 next
    applyStimulus(1'b1, 1'b0, 10'd1, 16'h0, 1'b1, 1'b0, 10'd510, 16'h0);
    stepCycle("tie_first", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd1, 16'h0, 1'b1, 1'b0, 10'd510, 16'h0);
    stepCycle("tie_second", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    repeat (3) stepCycle("drain0", 1'b0, 1'b0);

    // Fresh reset, then client 0 writes 5 and reads it back
    reset = 1'b0;
    stepCycle("rst2", 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 10'd5, 16'h0008, 1'b0, 1'b0, 10'd0, 16'h0);
    stepCycle("c0_wr5", 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'd5, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    stepCycle("c0_rd5", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    repeat (3) stepCycle("drain1", 1'b0, 1'b0);

    // Client 1 writes 510 then reads it the very next cycle
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b1, 10'd510, 16'h0020);
    stepCycle("c1_wr510", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'd510, 16'h0);
    stepCycle("c1_rd510", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    repeat (3) stepCycle("drain2", 1'b0, 1'b0);

    // Both clients stream reads: grants must alternate starting with 0
    applyStimulus(1'b1, 1'b0, 10'd1, 16'h0, 1'b1, 1'b0, 10'd510, 16'h0);
    for (int i = 0; i < 6; i++) begin
      stepCycle("alt", (i % 2) == 0, (i % 2) == 1);
    end
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    repeat (4) stepCycle("drain3", 1'b0, 1'b0);

    // Read granted, then reset the next cycle: the read must never return
    applyStimulus(1'b1, 1'b0, 10'd5, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    stepCycle("rd_before_rst", 1'b1, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0, 10'd7, 16'h0);
    stepCycle("rst_mid", 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0);
    repeat (5) stepCycle("post_rst", 1'b0, 1'b0);

    @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
